dds_fword_loader: RTL

Parametrised successor to the single-channel SPI frequency-word assembler. It parses the byte stream from the SPI slave into framed multi-channel DDS tuning words. Each word is held in a shadow register and committed atomically to its channel's active output, so the DDS phase accumulator never sees a half-written word. It sits between `spi_slaver` (rxd_out/rxd_flag, resynchronised into clk) and one or more `dds_addr` instances.

---
 rtl/dds_fword_loader.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dds_fword_loader.sv
// Parses the SPI byte stream into framed DDS tuning words: SYNC, CH, D0..Dn (+CK).
// Optional checksum byte enabled by defining DDS_FWORD_LOADER_CHECKSUM_EN.
module dds_fword_loader #(
    parameter int                        NUM_CH      = 2,
    parameter int                        WORD_BYTES  = 4,
    parameter logic [7:0]                SYNC_BYTE   = 8'h01,
    parameter int                        TIMEOUT_CYC = 65535,
    parameter logic [8*WORD_BYTES-1:0]   RST_WORD    = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic [NUM_CH*8*WORD_BYTES-1:0] word_out,
    output logic [NUM_CH-1:0]            update_stb,
    output logic                         busy,
    output logic                         frame_err,
    output logic [7:0]                   err_cnt,
    output logic [7:0]                   status
);

    // state  | meaning
    // IDLE   | waiting for SYNC_BYTE, other bytes dropped silently
    // CHAN   | expecting the channel byte
    // DATA   | collecting tuning-word bytes, little-endian
    // CSUM   | expecting the XOR checksum byte (checksum build only)
    // COMMIT | new word and update_stb visible; behaves as IDLE for input

    localparam int W     = 8 * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]       NUM_CH_B = 8'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHAN,
        S_DATA,
`ifdef DDS_FWORD_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_COMMIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          ch_q;
    logic [IDX_W-1:0]    idx;
    logic [W-1:0]        shadow;
    logic [W-1:0]        shadow_merge;
    logic [W-1:0]        commit_word;
    logic [TMR_W-1:0]    tmr;
    logic                tmr_exp;
    logic                ch_bad;
    logic                do_err;
    logic                do_commit;
    logic [NUM_CH*W-1:0] word_q;
    logic [NUM_CH-1:0]   stb_q;
    logic                err_q;
    logic [7:0]          err_cnt_q;
    logic                last_ok;
    logic                err_sticky;
    logic [3:0]          last_ch;
`ifdef DDS_FWORD_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign tmr_exp = (tmr == '0);
    assign ch_bad  = (rx_data >= NUM_CH_B);

    always_comb begin
        shadow_merge = shadow;
        shadow_merge[{idx, 3'b000} +: 8] = rx_data;
    end

    // The active word is loaded on the edge that enters COMMIT, so the new
    // value and its strobe are both visible during the COMMIT cycle.
`ifdef DDS_FWORD_LOADER_CHECKSUM_EN
    assign commit_word = shadow;
`else
    assign commit_word = shadow_merge;
`endif

    always_comb begin
        state_nxt = state;
        do_err    = 1'b0;
        do_commit = 1'b0;
        case (state)
            S_IDLE, S_COMMIT: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_nxt = S_CHAN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_CHAN: begin
                if (rx_valid) begin
                    if (ch_bad) begin
                        do_err    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else if (tmr_exp) begin
                    do_err    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    if (idx == IDX_LAST) begin
`ifdef DDS_FWORD_LOADER_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        do_commit = 1'b1;
                        state_nxt = S_COMMIT;
`endif
                    end
                end else if (tmr_exp) begin
                    do_err    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
`ifdef DDS_FWORD_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum) begin
                        do_commit = 1'b1;
                        state_nxt = S_COMMIT;
                    end else begin
                        do_err    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end else if (tmr_exp) begin
                    do_err    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Inter-byte timeout; every received byte reloads it, including SYNC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr <= TMR_LOAD;
        end else if (rx_valid) begin
            tmr <= TMR_LOAD;
        end else if (!tmr_exp) begin
            tmr <= tmr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q   <= '0;
            idx    <= '0;
            shadow <= '0;
        end else if (do_err) begin
            idx    <= '0;
            shadow <= '0;
        end else if (state == S_CHAN && rx_valid) begin
            ch_q   <= rx_data[3:0];
            idx    <= '0;
            shadow <= '0;
        end else if (state == S_DATA && rx_valid) begin
            shadow <= shadow_merge;
            idx    <= idx + 1'b1;
        end
    end

`ifdef DDS_FWORD_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum <= '0;
        end else if (rx_valid) begin
            if (state == S_CHAN) begin
                csum <= rx_data;
            end else if (state == S_DATA) begin
                csum <= csum ^ rx_data;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= {NUM_CH{RST_WORD}};
            stb_q  <= '0;
        end else begin
            stb_q <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (do_commit && ch_q == 4'(k)) begin
                    word_q[k*W +: W] <= commit_word;
                    stb_q[k]         <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            last_ok    <= 1'b0;
            err_sticky <= 1'b0;
            last_ch    <= '0;
        end else begin
            err_q <= do_err;
            if (do_err) begin
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
                err_sticky <= 1'b1;
                last_ok    <= 1'b0;
            end else if (do_commit) begin
                err_sticky <= 1'b0;
                last_ok    <= 1'b1;
                last_ch    <= ch_q;
            end
        end
    end

    assign word_out   = word_q;
    assign update_stb = stb_q;
    assign busy       = (state != S_IDLE);
    assign frame_err  = err_q;
    assign err_cnt    = err_cnt_q;
    assign status     = {last_ok, err_sticky, 2'b00, last_ch};

endmodule
